// File: rtl/bn_stats.sv
// Batch-norm statistics engine: streams one channel from iFM BRAM, accumulates sum and
// sum-of-squares, then derives mean, variance and a bit-serial integer square root.
module bn_stats #(
  parameter int unsigned HEIGHT = 4,
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned N      = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ps_control,
  output logic [31:0] pl_status,
  output logic [31:0] iFM_addr,
  input  logic [31:0] iFM_rddata,
  output logic [31:0] iFM_wrdata,
  output logic [3:0]  iFM_we,
  output logic [31:0] mean_out,
  output logic [63:0] var_out,
  output logic [31:0] std_out
);

  localparam int unsigned HW = HEIGHT * WIDTH;
  localparam int unsigned LG = $clog2(HW);
  localparam int unsigned CW = (LG > 5) ? LG : 5;
  localparam int unsigned SW = 32 + LG;
  localparam int unsigned QW = 64 + LG;

  typedef enum logic [2:0] {
    StIdle, StRead, StDrain, StMean, StVar, StSqrt, StDone
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [QW-1:0] sumsq_q, sumsq_d;
  logic [31:0]   mean_q, mean_d;
  logic [63:0]   msq_q, msq_d;
  logic [63:0]   var_q, var_d;
  logic [63:0]   rad_q, rad_d;
  logic [33:0]   rem_q, rem_d;
  logic [31:0]   root_q, root_d;
  logic [31:0]   mean_out_q, mean_out_d;
  logic [63:0]   var_out_q, var_out_d;
  logic [31:0]   std_out_q, std_out_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic        start;
  logic [63:0] word_sq;
  logic [33:0] trial, sub;
  logic        trial_ge;
  logic        unused_ok;

  assign start    = ps_control[0];
  assign word_sq  = 64'(iFM_rddata) * 64'(iFM_rddata);
  // Restoring step: bring down the next two radicand bits, try subtracting 4*root+1.
  assign trial    = {rem_q[31:0], rad_q[63:62]};
  assign sub      = {root_q, 2'b01};
  assign trial_ge = (trial >= sub);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    sum_d      = sum_q;
    sumsq_d    = sumsq_q;
    mean_d     = mean_q;
    msq_d      = msq_q;
    var_d      = var_q;
    rad_d      = rad_q;
    rem_d      = rem_q;
    root_d     = root_q;
    mean_out_d = mean_out_q;
    var_out_d  = var_out_q;
    std_out_d  = std_out_q;
    done_d     = done_q;
    err_d      = err_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sum_d   = '0;
          sumsq_d = '0;
          if (32'(ps_control[15:8]) >= N) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            addr_d  = 32'(ps_control[15:8]) * 32'(HW * 4);
            cnt_d   = '0;
            state_d = StRead;
          end
        end
      end
      StRead: begin
        // Read data lags the address by one cycle, so the first issue has nothing to capture.
        if (cnt_q != '0) begin
          sum_d   = sum_q + SW'(iFM_rddata);
          sumsq_d = sumsq_q + QW'(word_sq);
        end
        if (cnt_q == CW'(HW - 1)) begin
          state_d = StDrain;
        end else begin
          addr_d = addr_q + 32'd4;
          cnt_d  = cnt_q + 1'b1;
        end
      end
      StDrain: begin
        sum_d   = sum_q + SW'(iFM_rddata);
        sumsq_d = sumsq_q + QW'(word_sq);
        state_d = StMean;
      end
      StMean: begin
        mean_d  = sum_q[SW-1:LG];
        msq_d   = sumsq_q[QW-1:LG];
        state_d = StVar;
      end
      StVar: begin
        var_d   = msq_q - 64'(mean_q) * 64'(mean_q);
        rad_d   = var_d;
        rem_d   = '0;
        root_d  = '0;
        cnt_d   = '0;
        state_d = StSqrt;
      end
      StSqrt: begin
        rem_d  = trial_ge ? (trial - sub) : trial;
        root_d = {root_q[30:0], trial_ge};
        rad_d  = {rad_q[61:0], 2'b00};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(31)) begin
          mean_out_d = mean_q;
          var_out_d  = var_q;
          std_out_d  = root_d;
          state_d    = StDone;
        end
      end
      StDone: begin
        // Guarantee done is seen for at least one cycle before the handshake can close.
        if (!done_q) begin
          done_d = 1'b1;
        end else if (!start) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      sum_q      <= '0;
      sumsq_q    <= '0;
      mean_q     <= '0;
      msq_q      <= '0;
      var_q      <= '0;
      rad_q      <= '0;
      rem_q      <= '0;
      root_q     <= '0;
      mean_out_q <= '0;
      var_out_q  <= '0;
      std_out_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      sum_q      <= sum_d;
      sumsq_q    <= sumsq_d;
      mean_q     <= mean_d;
      msq_q      <= msq_d;
      var_q      <= var_d;
      rad_q      <= rad_d;
      rem_q      <= rem_d;
      root_q     <= root_d;
      mean_out_q <= mean_out_d;
      var_out_q  <= var_out_d;
      std_out_q  <= std_out_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign pl_status  = {30'd0, err_q, done_q};
  assign iFM_addr   = addr_q;
  assign iFM_wrdata = '0;
  assign iFM_we     = '0;
  assign mean_out   = mean_out_q;
  assign var_out    = var_out_q;
  assign std_out    = std_out_q;

  assign unused_ok = ^{ps_control[31:16], ps_control[7:1], sum_q[LG-1:0], sumsq_q[LG-1:0],
                       rem_q[33:32], root_q[31]};

endmodule
